// File: rtl/nitc_pkg.sv
// Shared definitions for the NITC RISC24 boot path: word width, sync marker
// and the loader state encoding.
package nitc_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream image loader: SYNC, 16-bit length, big-endian words, optional XOR
// checksum (enabled by defining BOOT_CHECKSUM_EN). Holds the core in reset until loaded.
module boot_loader
    import nitc_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                MEM_DEPTH = 20,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              boot_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [WORD_W-1:0] DEPTH = WORD_W'(MEM_DEPTH);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic [WORD_W-1:0] count;
    logic [WORD_W-1:0] word_cnt;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] len_full;
    logic [BYTE_W-1:0] hi_byte;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    // A byte offered alongside boot_start is dropped rather than parsed.
    assign accept    = in_valid && in_ready && !boot_start;
    assign word_next = word_cnt + 16'd1;
    assign len_full  = {count[15:8], in_data};

    // State register.
    // NOTE: every flop is updated with <= so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        if (boot_start) begin
            next_state = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE:    if (in_data == SYNC_BYTE) next_state = LEN_HI;
                LEN_HI:  next_state = LEN_LO;
                LEN_LO: begin
                    if (len_full > DEPTH) begin
                        next_state = ERROR;
                    end else if (len_full == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = DATA_HI;
                    end
                end
                DATA_HI: next_state = DATA_LO;
                DATA_LO: begin
                    if (word_next == count) begin
`ifdef BOOT_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = DATA_HI;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CSUM:    next_state = (in_data == csum) ? DONE : ERROR;
`endif
                default: next_state = state;
            endcase
        end
    end

    // Output logic: ready is decoded from state; status flags are registered
    // from next_state so they appear on the first cycle of DONE/ERROR.
    always_comb begin
        in_ready = (state != DONE) && (state != ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            done      <= (next_state == DONE);
            error     <= (next_state == ERROR);
            cpu_reset <= (next_state != DONE);
        end
    end

    // Length capture, byte-to-word assembly and the write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            word_cnt  <= '0;
            hi_byte   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (boot_start) begin
            count    <= '0;
            word_cnt <= '0;
            mem_we   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                unique case (state)
                    LEN_HI:  count[15:8] <= in_data;
                    LEN_LO:  count[7:0]  <= in_data;
                    DATA_HI: hi_byte     <= in_data;
                    DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {hi_byte, in_data};
                        mem_addr  <= ADDR_W'(word_cnt);
                        word_cnt  <= word_next;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running XOR over length and data bytes; the sync byte restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (boot_start) begin
            csum <= '0;
        end else if (accept) begin
            unique case (state)
                IDLE:                            if (in_data == SYNC_BYTE) csum <= '0;
                LEN_HI, LEN_LO, DATA_HI, DATA_LO: csum <= csum ^ in_data;
                default: ;
            endcase
        end
    end
`endif

endmodule
